pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the Chronos RV32I 5-stage pipeline.
- Merges the combinational load-use stall from hazard detection, branch/jump redirects from EX, trap requests, multi-cycle EX busy and data-memory wait into per-stage write enables, flushes, a bubble select and the PC mux select.
- Adds state the hazard unit lacks: wait states, a post-redirect kill window, a pending-redirect latch, a stall counter and a memory-wait watchdog.
- Sits between the hazard unit, the EX/MEM stages and the PC/pipeline registers in the core top level.

Parameters:
FLUSH_CYCLES, 1, extra cycles IF is killed after a redirect (covers synchronous IMEM latency); 1..7
CNT_W, 32, width of the saturating stall-cycle counter
TIMEOUT, 255, max consecutive MEM_WAIT cycles before timeout_err; 1..65535

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
load_use  in  1  load-use stall request from hazard detection
branch_taken  in  1  EX resolved a taken branch/jump; held while EX is frozen
trap_req  in  1  exception/ecall request from EX; held while EX is frozen
ex_busy  in  1  multi-cycle EX op not finished
mem_stall  in  1  data memory not ready
pc_sel  out  3  000 hold, 001 PC+4, 010 branch target, 100 trap vector
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID enable
idex_write  out  1  ID/EX enable
exmem_write  out  1  EX/MEM enable
memwb_write  out  1  MEM/WB enable
flush_ifid  out  1  clear IF/ID to NOP
flush_idex  out  1  clear ID/EX to NOP
bubble_sel  out  1  ID/EX control-zero mux select
stall_cnt  out  CNT_W  cycles with pc_write=0; saturates at all-ones
timeout_err  out  1  sticky watchdog flag

Behaviour:
- States: RUN, MEM_WAIT, EX_WAIT, FLUSH. Reset -> RUN, redirect_pend=0, pend_kind=0, flush_cnt=0, wait_cnt=0, stall_cnt=0, timeout_err=0.
- Outputs are combinational from state and inputs. During reset all enables are 1, flushes and bubble_sel are 0, and pc_sel=001.
- Input priority, evaluated every cycle in every state: mem_stall > ex_busy > trap_req > branch_taken > load_use.
- mem_stall=1:
  - All enables 0, pc_sel=000, no flush.
  - If trap_req or branch_taken is high: set redirect_pend=1 and pend_kind=trap_req, so trap wins over branch.
  - Next state MEM_WAIT. wait_cnt increments while in MEM_WAIT and clears on any other state.
- ex_busy=1 (mem_stall=0):
  - pc_write, ifid_write, idex_write = 0; exmem_write=1; memwb_write=1.
  - flush_idex=0; the EX/MEM input is bubbled by the EX unit, not here.
  - Next state EX_WAIT.
- Redirect: trap_req, branch_taken or redirect_pend, with both stalls low.
  - pc_sel=100 if trap (or pend_kind=1), else 010.
  - flush_ifid=1, flush_idex=1, all enables 1.
  - Clear redirect_pend. Load flush_cnt=FLUSH_CYCLES. Next state FLUSH.
- FLUSH, no higher-priority event:
  - flush_ifid=1, pc_sel=001, enables 1.
  - Decrement flush_cnt; go to RUN when it reaches 1.
  - load_use is ignored in FLUSH because IF/ID holds a killed instruction.
- load_use in RUN/EX_WAIT/MEM_WAIT exit (no higher event):
  - pc_write=0, ifid_write=0, pc_sel=000, bubble_sel=1, flush_idex=1. Other enables 1. Stay in RUN.
- Otherwise: pc_sel=001, all enables 1, no flush. Next state RUN.
- A new redirect during FLUSH restarts the redirect sequence, with flush_cnt reloaded.
- Watchdog: timeout_err is set when wait_cnt reaches TIMEOUT. It stays set until reset and has no effect on stalling.
- stall_cnt increments on every cycle where pc_write=0, saturating at 2^CNT_W-1.
- Asynchronous reset mid-stall discards redirect_pend and returns to RUN immediately.

Decomposition:
- Add to defines.vh:
  - PC_SEL_HOLD/PC4/BRANCH/TRAP encodings (000/001/010/100).
  - State encodings CTRL_RUN/MEM_WAIT/EX_WAIT/FLUSH.
- One sub-module: sat_counter (parameterised width, inc, clr, saturating). Instantiated for stall_cnt and wait_cnt.

Test Plan:
- Reset release, no requests, 10 cycles -> all enables 1, pc_sel=001, stall_cnt=0.
- load_use pulse 1 cycle in RUN -> that cycle pc_write=0, ifid_write=0, bubble_sel=1, flush_idex=1, pc_sel=000; next cycle normal; stall_cnt=1.
- branch_taken 1 cycle, FLUSH_CYCLES=2 -> cycle0 pc_sel=010 with flush_ifid=flush_idex=1; cycles1-2 flush_ifid=1, pc_sel=001; cycle3 RUN. load_use held high in cycles 1-2 is ignored.
- mem_stall 4 cycles with trap_req and branch_taken high in cycle1 -> 4 cycles of all-zero enables and pc_sel=000; then pc_sel=100 with flushes; stall_cnt=4.
- ex_busy 3 cycles plus simultaneous load_use -> pc/ifid/idex frozen, exmem/memwb=1, bubble_sel=0 for 3 cycles; then load_use bubble cycle.
- TIMEOUT=5, mem_stall held 8 cycles -> timeout_err rises on 5th MEM_WAIT cycle and stays 1 after mem_stall drops; async rst mid-stall -> RUN and timeout_err=0 within the reset cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and the packed control word for the pipeline stall/flush sequencer.
// States are plain localparam constants so legacy code that compares raw values still lines up.
package pipeline_ctrl_pkg;

  localparam logic [2:0] PC_SEL_HOLD   = 3'b000;
  localparam logic [2:0] PC_SEL_PC4    = 3'b001;
  localparam logic [2:0] PC_SEL_BRANCH = 3'b010;
  localparam logic [2:0] PC_SEL_TRAP   = 3'b100;

  localparam logic [1:0] CTRL_RUN      = 2'd0;
  localparam logic [1:0] CTRL_MEM_WAIT = 2'd1;
  localparam logic [1:0] CTRL_EX_WAIT  = 2'd2;
  localparam logic [1:0] CTRL_FLUSH    = 2'd3;

  // Enable order: pc, if/id, id/ex, ex/mem, mem/wb; flag order: flush_ifid, flush_idex, bubble
  typedef struct packed {
    logic [2:0] pc_sel;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       memwb_write;
    logic       flush_ifid;
    logic       flush_idex;
    logic       bubble_sel;
  } ctrl_t;

  function automatic ctrl_t ctrl_word(input logic [2:0] sel, input logic [4:0] en,
                                      input logic [2:0] flags);
    return ctrl_t'({sel, en, flags});
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module pipeline_ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges hazard, redirect, trap and
// memory/EX wait requests into stage enables, flushes, bubble select and the PC mux select.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             trap_req,
  input  logic             ex_busy,
  input  logic             mem_stall,
  output logic [2:0]       pc_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             bubble_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        redirect_pend;
  logic        pend_kind;
  logic [2:0]  flush_cnt;
  logic [15:0] wait_cnt;
  logic        timeout_q;
  logic        wait_hit;
  logic        latch_pend;
  logic        take_redirect;
  logic        flush_step;
  logic        redirect_req;
  logic        trap_sel;
  logic        mem_wait_next;
  ctrl_t       ctrl;

  assign redirect_req = trap_req | branch_taken | redirect_pend;
  assign trap_sel     = trap_req | (redirect_pend & pend_kind);

  // Priority chain: mem_stall > ex_busy > redirect > flush window > load_use > normal
  always_comb begin
    ctrl          = ctrl_word(PC_SEL_PC4, 5'b11111, 3'b000);
    next_state    = CTRL_RUN;
    latch_pend    = 1'b0;
    take_redirect = 1'b0;
    flush_step    = 1'b0;
    if (mem_stall) begin
      ctrl       = ctrl_word(PC_SEL_HOLD, 5'b00000, 3'b000);
      next_state = CTRL_MEM_WAIT;
      latch_pend = trap_req | branch_taken;
    end else if (ex_busy) begin
      ctrl       = ctrl_word(PC_SEL_HOLD, 5'b00011, 3'b000);
      next_state = CTRL_EX_WAIT;
    end else if (redirect_req) begin
      ctrl          = ctrl_word(trap_sel ? PC_SEL_TRAP : PC_SEL_BRANCH, 5'b11111, 3'b110);
      next_state    = CTRL_FLUSH;
      take_redirect = 1'b1;
    end else if (state == CTRL_FLUSH) begin
      // IF/ID holds a killed fetch here, so a load-use request against it is meaningless
      ctrl       = ctrl_word(PC_SEL_PC4, 5'b11111, 3'b100);
      next_state = (flush_cnt <= 3'd1) ? CTRL_RUN : CTRL_FLUSH;
      flush_step = 1'b1;
    end else if (load_use) begin
      ctrl = ctrl_word(PC_SEL_HOLD, 5'b00111, 3'b011);
    end
    if (rst)
      ctrl = ctrl_word(PC_SEL_PC4, 5'b11111, 3'b000);
  end

  assign pc_sel      = ctrl.pc_sel;
  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign exmem_write = ctrl.exmem_write;
  assign memwb_write = ctrl.memwb_write;
  assign flush_ifid  = ctrl.flush_ifid;
  assign flush_idex  = ctrl.flush_idex;
  assign bubble_sel  = ctrl.bubble_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= CTRL_RUN;
    else
      state <= next_state;
  end

  // A trap seen at any point of a memory stall outranks a branch seen during the same stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pend <= 1'b0;
      pend_kind     <= 1'b0;
    end else if (latch_pend) begin
      redirect_pend <= 1'b1;
      pend_kind     <= pend_kind | trap_req;
    end else if (take_redirect) begin
      redirect_pend <= 1'b0;
      pend_kind     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_cnt <= 3'd0;
    else if (take_redirect)
      flush_cnt <= FLUSH_LOAD;
    else if (flush_step)
      flush_cnt <= flush_cnt - 3'd1;
  end

  // wait_cnt reads as the 1-based index of the current MEM_WAIT cycle
  assign mem_wait_next = (next_state == CTRL_MEM_WAIT);
  assign wait_hit      = (wait_cnt >= TIMEOUT_W);
  assign timeout_err   = timeout_q | wait_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_q <= 1'b0;
    else if (wait_hit)
      timeout_q <= 1'b1;
  end

  pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl.pc_write),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  pipeline_ctrl_sat_counter #(.W(16)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_wait_next),
    .clr   (~mem_wait_next),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized run against
// a cycle-level model built from the stall/redirect priority rules.
module tb_pipeline_ctrl;

  localparam int FC = 2;
  localparam int TO = 5;
  localparam int CW = 8;

  // {pc_sel, pc_write, ifid, idex, exmem, memwb, flush_ifid, flush_idex, bubble_sel}
  localparam logic [10:0] NORMAL   = 11'b001_11111_000;
  localparam logic [10:0] LOADUSE  = 11'b000_00111_011;
  localparam logic [10:0] MEMSTALL = 11'b000_00000_000;
  localparam logic [10:0] EXBUSY   = 11'b000_00011_000;
  localparam logic [10:0] BRANCH   = 11'b010_11111_110;
  localparam logic [10:0] TRAP     = 11'b100_11111_110;
  localparam logic [10:0] FLUSHC   = 11'b001_11111_100;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_use, branch_taken, trap_req, ex_busy, mem_stall;
  logic [2:0]    pc_sel;
  logic          pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic          flush_ifid, flush_idex, bubble_sel;
  logic [CW-1:0] stall_cnt;
  logic          timeout_err;
  logic [10:0]   obs;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .trap_req     (trap_req),
    .ex_busy      (ex_busy),
    .mem_stall    (mem_stall),
    .pc_sel       (pc_sel),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .memwb_write  (memwb_write),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .bubble_sel   (bubble_sel),
    .stall_cnt    (stall_cnt),
    .timeout_err  (timeout_err)
  );

  assign obs = {pc_sel, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                flush_ifid, flush_idex, bubble_sel};

  task automatic drive(input bit ms, input bit eb, input bit tr, input bit br, input bit lu);
    mem_stall    = ms;
    ex_busy      = eb;
    trap_req     = tr;
    branch_taken = br;
    load_use     = lu;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs !== NORMAL) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, NORMAL);
    end
    n_cmp++;
    if (stall_cnt !== '0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: got cnt=%0d to=%b expected cnt=0 to=0", stall_cnt, timeout_err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== NORMAL || stall_cnt !== '0) begin
        n_fail++;
        $display("[TB] FAIL idle_run[%0d]: got %b cnt=%0d expected %b cnt=0", i, obs, stall_cnt, NORMAL);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    n_cmp++;
    if (obs !== LOADUSE) begin
      n_fail++;
      $display("[TB] FAIL load_use_bubble: got %b expected %b", obs, LOADUSE);
    end
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs !== NORMAL || stall_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL load_use_after: got %b cnt=%0d expected %b cnt=1", obs, stall_cnt, NORMAL);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch_flush();
    logic [10:0] want [5];
    bit          lu_seq [5];
    want   = '{BRANCH, FLUSHC, FLUSHC, LOADUSE, NORMAL};
    lu_seq = '{0, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, (i == 0), lu_seq[i]);
      @(negedge clk);
      n_cmp++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("[TB] FAIL branch_flush[%0d]: got %b expected %b", i, obs, want[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_redirect();
    logic [10:0] want [8];
    want = '{MEMSTALL, MEMSTALL, MEMSTALL, MEMSTALL, TRAP, FLUSHC, FLUSHC, NORMAL};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive((i < 4), 0, (i == 1), (i == 1), 0);
      @(negedge clk);
      n_cmp++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("[TB] FAIL mem_redirect[%0d]: got %b expected %b", i, obs, want[i]);
      end
      if (i == 4) begin
        n_cmp++;
        if (stall_cnt !== 8'd4) begin
          n_fail++;
          $display("[TB] FAIL mem_stall_cnt: got %0d expected 4", stall_cnt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ex_busy();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, (i < 3), 0, 0, (i < 4));
      @(negedge clk);
      n_cmp++;
      if (obs !== ((i < 3) ? EXBUSY : (i == 3) ? LOADUSE : NORMAL)) begin
        n_fail++;
        $display("[TB] FAIL ex_busy[%0d]: got %b", i, obs);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (stall_cnt !== 8'd4) begin
      n_fail++;
      $display("[TB] FAIL ex_busy_cnt: got %0d expected 4", stall_cnt);
    end
  endtask

  task automatic test_timeout_reset();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive((k <= 8), 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (timeout_err !== (k >= 6)) begin
        n_fail++;
        $display("[TB] FAIL timeout[%0d]: got %b expected %b", k, timeout_err, (k >= 6));
      end
      @(posedge clk);
      #1;
    end
    drive(1, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== NORMAL || timeout_err !== 1'b0 || stall_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b to=%b cnt=%0d expected %b to=0 cnt=0",
               obs, timeout_err, stall_cnt, NORMAL);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs !== NORMAL) begin
      n_fail++;
      $display("[TB] FAIL pend_discard: got %b expected %b", obs, NORMAL);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 0, 0, 0, 0);
    repeat (260) @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 8'hFF) begin
      n_fail++;
      $display("[TB] FAIL stall_saturate: got %0d expected 255", stall_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  // Model: flush_left = killed-fetch cycles still owed after a redirect; mem_len = consecutive
  // stalled cycles already spent in the memory wait.
  task automatic test_random(input int cycles);
    int          flush_left, mem_len, m_stall;
    bit          pend, pend_trap, sticky, exp_to;
    bit          ms, eb, tr, br, lu;
    logic [10:0] exp;
    do_reset();
    flush_left = 0; mem_len = 0; m_stall = 0;
    pend = 0; pend_trap = 0; sticky = 0;
    for (int i = 0; i < cycles; i++) begin
      ms = ($urandom_range(0, 99) < 15);
      eb = ($urandom_range(0, 99) < 15);
      tr = ($urandom_range(0, 99) < 6);
      br = ($urandom_range(0, 99) < 15);
      lu = ($urandom_range(0, 99) < 25);
      drive(ms, eb, tr, br, lu);
      if (ms) begin
        exp = MEMSTALL;
        if (tr || br) begin
          pend = 1;
          pend_trap = pend_trap | tr;
        end
        flush_left = 0;
      end else if (eb) begin
        exp = EXBUSY;
        flush_left = 0;
      end else if (tr || br || pend) begin
        exp = (tr || (pend && pend_trap)) ? TRAP : BRANCH;
        pend = 0;
        pend_trap = 0;
        flush_left = FC;
      end else if (flush_left > 0) begin
        exp = FLUSHC;
        flush_left--;
      end else if (lu) begin
        exp = LOADUSE;
      end else begin
        exp = NORMAL;
      end
      exp_to = sticky || (mem_len >= TO);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl[%0d]: got %b expected %b", i, obs, exp);
      end
      n_cmp++;
      if (stall_cnt !== CW'(m_stall)) begin
        n_fail++;
        $display("[TB] FAIL rand_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, m_stall);
      end
      n_cmp++;
      if (timeout_err !== exp_to) begin
        n_fail++;
        $display("[TB] FAIL rand_timeout[%0d]: got %b expected %b", i, timeout_err, exp_to);
      end
      sticky  = exp_to;
      mem_len = ms ? mem_len + 1 : 0;
      if (!exp[7] && m_stall < 255) m_stall++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mem_redirect();
    test_ex_busy();
    test_timeout_reset();
    test_saturation();
    test_random(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
